coin_input_conditioner: RTL and testbench

Upstream front end for the vending-machine credit FSM. Takes the raw coin (m) and accept (a) switch inputs and synchronizes them into the prescaled FSM clock domain. Debounces each input and emits clean single-cycle pulses that drive the credit FSM's m/a inputs. Also serializes simultaneous coin/accept events and exposes a saturating glitch counter for bring-up debug.

---
 rtl/vending_pkg.sv | 17 +
 rtl/debounce_channel.sv | 113 +++++++++++
 rtl/coin_input_conditioner.sv | 119 +++++++++++
 tb/tb_coin_input_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending-machine front end.
// Holds the debounce channel state encoding, the glitch counter ceiling
// and the default debounce length so that the RTL and its benches agree.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // debounced level is low and s2 agrees
    RISE_CHK = 2'd1,  // s2 went high, counting stable high samples
    HIGH     = 2'd2,  // debounced level is high and s2 agrees
    FALL_CHK = 2'd3   // s2 went low, counting stable low samples
  } chan_state_t;

  localparam int DEB_CYCLES_DEFAULT = 4;
  localparam int GLITCH_MAX         = 15;
  localparam int GLITCH_W           = 4;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, debounce FSM and stability counter.
// Ports:
//   clk, reset  - FSM clock, asynchronous active-high reset
//   raw         - raw switch input, asynchronous to clk
//   level       - debounced level
//   rise        - one-cycle event when a low->high change is accepted
//   abort       - one-cycle event when a pending change is rejected as too short
// level/rise/abort are all registered; they change on the edge at which the
// FSM decides, so downstream logic sees them one edge after that decision.
module debounce_channel
  import vending_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(DEB_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic abort
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = RISE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RISE_CHK: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = FALL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_CHK: begin
        // Release is accepted silently; only presses generate events.
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      abort_q <= abort_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign abort = abort_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin/accept front end for the credit FSM.
// Debounces both raw switches, turns accepted presses into single-cycle
// pulses, serializes simultaneous presses and counts rejected glitches.
// Ports:
//   clk, reset                 - FSM clock, asynchronous active-high reset
//   coin_raw, accept_raw       - raw switches, asynchronous to clk
//   coin_pulse, accept_pulse   - registered one-cycle press pulses, never together
//   coin_level, accept_level   - registered debounced levels
//   glitch_cnt                 - saturating count of aborted debounces
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_raw,
  input  logic                accept_raw,
  output logic                coin_pulse,
  output logic                accept_pulse,
  output logic                coin_level,
  output logic                accept_level,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;

  logic coin_lvl, coin_rise, coin_abort;
  logic acc_lvl, acc_rise, acc_abort;

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_coin (
    .clk   (clk),
    .reset (reset),
    .raw   (coin_raw),
    .level (coin_lvl),
    .rise  (coin_rise),
    .abort (coin_abort)
  );

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_accept (
    .clk   (clk),
    .reset (reset),
    .raw   (accept_raw),
    .level (acc_lvl),
    .rise  (acc_rise),
    .abort (acc_abort)
  );

  logic                coin_pulse_q, coin_pulse_d;
  logic                acc_pulse_q, acc_pulse_d;
  logic                pend_coin_q, pend_coin_d;
  logic                pend_acc_q, pend_acc_d;
  logic                coin_level_q, accept_level_q;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                coin_req, acc_req;
  logic [1:0]          glitch_inc;
  logic [GLITCH_W:0]   glitch_sum;

  // A request is a fresh rise or a press that lost arbitration last cycle.
  // Coin wins a tie unless accept is the one already waiting, so a deferred
  // press is never starved.
  always_comb begin
    coin_req    = coin_rise | pend_coin_q;
    acc_req     = acc_rise | pend_acc_q;
    coin_pulse_d = 1'b0;
    acc_pulse_d  = 1'b0;
    pend_coin_d  = 1'b0;
    pend_acc_d   = 1'b0;
    if (coin_req && acc_req) begin
      if (pend_acc_q) begin
        acc_pulse_d = 1'b1;
        pend_coin_d = 1'b1;
      end else begin
        coin_pulse_d = 1'b1;
        pend_acc_d   = 1'b1;
      end
    end else begin
      coin_pulse_d = coin_req;
      acc_pulse_d  = acc_req;
    end
  end

  always_comb begin
    glitch_inc = {1'b0, coin_abort} + {1'b0, acc_abort};
    glitch_sum = {1'b0, glitch_q} + {{(GLITCH_W-1){1'b0}}, glitch_inc};
    if (glitch_sum > (GLITCH_W+1)'(GLITCH_MAX)) begin
      glitch_d = GLITCH_W'(GLITCH_MAX);
    end else begin
      glitch_d = glitch_sum[GLITCH_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_pulse_q   <= 1'b0;
      acc_pulse_q    <= 1'b0;
      pend_coin_q    <= 1'b0;
      pend_acc_q     <= 1'b0;
      coin_level_q   <= 1'b0;
      accept_level_q <= 1'b0;
      glitch_q       <= '0;
    end else begin
      coin_pulse_q   <= coin_pulse_d;
      acc_pulse_q    <= acc_pulse_d;
      pend_coin_q    <= pend_coin_d;
      pend_acc_q     <= pend_acc_d;
      coin_level_q   <= coin_lvl;
      accept_level_q <= acc_lvl;
      glitch_q       <= glitch_d;
    end
  end

  assign coin_pulse   = coin_pulse_q;
  assign accept_pulse = acc_pulse_q;
  assign coin_level   = coin_level_q;
  assign accept_level = accept_level_q;
  assign glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;
  import vending_pkg::*;

  localparam int DEB = DEB_CYCLES_DEFAULT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_raw = 1'b0;
  logic accept_raw = 1'b0;
  logic coin_pulse, accept_pulse, coin_level, accept_level;
  logic [3:0] glitch_cnt;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_raw     (coin_raw),
    .accept_raw   (accept_raw),
    .coin_pulse   (coin_pulse),
    .accept_pulse (accept_pulse),
    .coin_level   (coin_level),
    .accept_level (accept_level),
    .glitch_cnt   (glitch_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at edge", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel's level flips once DEB consecutive synchronized samples disagree
  // with it; a disagreeing run cut short counts as a glitch. Raw inputs reach
  // the decision two edges late and the outputs show it one edge later.
  bit m_s1[2] = '{0, 0};
  bit m_s2[2] = '{0, 0};
  bit m_lvl[2] = '{0, 0};
  int m_run[2] = '{0, 0};
  bit m_rise[2] = '{0, 0};
  bit m_abort[2] = '{0, 0};
  bit m_wait_coin = 0, m_wait_acc = 0;
  bit e_cp = 0, e_ap = 0, e_cl = 0, e_al = 0;
  int e_gl = 0;

  int edge_n = 0;
  int cp_total = 0, ap_total = 0;
  int cp_edge_last = -1, ap_edge_last = -1;

  // expected-output queue: model pushes, compare pops the same cycle
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    bit cr, ar, raw_now[2];
    edge_n++;
    raw_now[0] = coin_raw;
    raw_now[1] = accept_raw;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
        m_rise[c] = 0; m_abort[c] = 0;
      end
      m_wait_coin = 0; m_wait_acc = 0;
      e_cp = 0; e_ap = 0; e_cl = 0; e_al = 0; e_gl = 0;
    end else begin
      // output stage works on the channel events of the previous edge
      cr = m_rise[0] || m_wait_coin;
      ar = m_rise[1] || m_wait_acc;
      if (cr && ar) begin
        if (m_wait_acc) begin
          e_cp = 0; e_ap = 1; m_wait_coin = 1; m_wait_acc = 0;
        end else begin
          e_cp = 1; e_ap = 0; m_wait_acc = 1; m_wait_coin = 0;
        end
      end else begin
        e_cp = cr; e_ap = ar; m_wait_coin = 0; m_wait_acc = 0;
      end
      e_cl = m_lvl[0];
      e_al = m_lvl[1];
      e_gl = e_gl + int'(m_abort[0]) + int'(m_abort[1]);
      if (e_gl > 15) e_gl = 15;
      // channel decisions on the doubly-delayed sample
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 0;
        m_abort[c] = 0;
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c] = m_s2[c];
            m_rise[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          if (m_run[c] > 0) m_abort[c] = 1;
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_now[c];
      end
    end
    exp_q.push_back({e_cp, e_ap, e_cl, e_al, 4'(e_gl)});

    // ---------------- compare ----------------
    #2;
    begin
      logic [7:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {coin_pulse, accept_pulse, coin_level, accept_level, glitch_cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs edge=%0d actual{cp,ap,cl,al,gl}=%b expected=%b",
                 edge_n, act_v, exp_v);
      end
      if (coin_pulse === 1'b1) begin cp_total++; cp_edge_last = edge_n; end
      if (accept_pulse === 1'b1) begin ap_total++; ap_edge_last = edge_n; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    coin_raw = 1'b0;
    accept_raw = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, cp0, ap0;

    // 1: reset then idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(20);
    check("idle_glitch", int'(glitch_cnt), 0);
    check("idle_pulses", cp_total + ap_total, 0);

    // 2: clean coin press and release
    do_reset();
    cp0 = cp_total;
    coin_raw = 1'b1;
    t0 = edge_n + 1;
    tick(20);
    check("press_count", cp_total - cp0, 1);
    check("press_latency", cp_edge_last - t0, 6);
    check("press_level", int'(coin_level), 1);
    coin_raw = 1'b0;
    t0 = edge_n + 1;
    tick(6);
    check("release_level_5", int'(coin_level), 1);
    tick(1);
    check("release_level_6", int'(coin_level), 0);
    tick(10);
    check("release_no_pulse", cp_total - cp0, 1);

    // 3: bounce then a clean press
    do_reset();
    cp0 = cp_total;
    coin_raw = 1'b1; tick(2);
    coin_raw = 1'b0; tick(1);
    coin_raw = 1'b1; tick(10);
    coin_raw = 1'b0; tick(12);
    check("bounce_glitch", int'(glitch_cnt), 1);
    check("bounce_pulses", cp_total - cp0, 1);

    // 4: simultaneous press
    do_reset();
    cp0 = cp_total;
    ap0 = ap_total;
    coin_raw = 1'b1;
    accept_raw = 1'b1;
    tick(14);
    check("simul_coin", cp_total - cp0, 1);
    check("simul_accept", ap_total - ap0, 1);
    check("simul_order", ap_edge_last - cp_edge_last, 1);
    coin_raw = 1'b0;
    accept_raw = 1'b0;
    tick(10);

    // 5: glitch counter saturation
    do_reset();
    cp0 = cp_total;
    ap0 = ap_total;
    for (int i = 0; i < 20; i++) begin
      accept_raw = 1'b1; tick(1);
      accept_raw = 1'b0; tick(5);
    end
    check("sat_15", int'(glitch_cnt), 15);
    for (int i = 0; i < 2; i++) begin
      coin_raw = 1'b1; accept_raw = 1'b1; tick(1);
      coin_raw = 1'b0; accept_raw = 1'b0; tick(5);
    end
    check("sat_hold", int'(glitch_cnt), 15);
    check("sat_no_pulse", (cp_total - cp0) + (ap_total - ap0), 0);

    // 6: reset in the middle of a debounce
    do_reset();
    ap0 = ap_total;
    accept_raw = 1'b1;
    t0 = edge_n + 1;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(15);
    check("midrst_count", ap_total - ap0, 1);
    check("midrst_latency", ap_edge_last - (t0 + 5), DEB + 2);
    accept_raw = 1'b0;
    tick(10);

    // random phase, checked every cycle against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0) coin_raw = ~coin_raw;
      if ($urandom_range(0, 4) == 0) accept_raw = ~accept_raw;
      if ($urandom_range(0, 39) == 0) begin
        coin_raw = 1'b1;
        accept_raw = 1'b1;
      end
      tick(1);
    end
    reset = 1'b0;
    coin_raw = 1'b0;
    accept_raw = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
